// File: rtl/mux_scan_sequencer_pkg.sv
// Shared state encoding and channel constants for the mux scan sequencer.
package mux_scan_sequencer_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/mux_scan_sequencer_dwell_counter.sv
// Settle-time counter: counts up from 0 while enabled and stops at DWELL-1,
// where tc is raised; it never wraps.
module dwell_counter #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = $clog2(DWELL + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc = (cnt_q == CNT_W'(DWELL - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !tc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps an external 4:1 mux through all channels, waits DWELL cycles on each,
// samples its output and publishes the four samples as one packed frame.
module mux_scan_sequencer
    import mux_scan_sequencer_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CW    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                auto,
    input  logic [CW-1:0]       y_in,
    output logic [SEL_W-1:0]    sel,
    output logic [NCH*CW-1:0]   frame,
    output logic                frame_valid,
    output logic                busy
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NCH - 1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NCH*CW-1:0]  frame_q;
    logic [NCH*CW-1:0]  frame_d;
    logic               cnt_clr;
    logic               cnt_en;
    logic               cnt_tc;
    logic               last_capture;

    // Only channels 0..2 need shadow slots; channel 3 is merged straight into the frame.
    logic [CW-1:0]      shadow_q [NCH-1];

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_clr = 1'b1;
        cnt_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                    sel_d   = '0;
                end
            end
            ST_SETTLE: begin
                cnt_clr = 1'b0;
                cnt_en  = 1'b1;
                if (cnt_tc) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (sel_q == LAST_CH) begin
                    state_d = ST_DONE;
                end else begin
                    sel_d   = sel_q + SEL_W'(1);
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: begin
                if (auto) begin
                    state_d = ST_SETTLE;
                    sel_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    assign last_capture = (state_q == ST_CAPTURE) && (sel_q == LAST_CH);

    genvar gi;
    generate
        for (gi = 0; gi < NCH - 1; gi++) begin : g_shadow
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_q[gi] <= '0;
                end else if ((state_q == ST_CAPTURE) && (sel_q == SEL_W'(gi))) begin
                    shadow_q[gi] <= y_in;
                end
            end
            assign frame_d[CW*gi +: CW] = shadow_q[gi];
        end
    endgenerate

    assign frame_d[CW*(NCH-1) +: CW] = y_in;

    // Frame is loaded on the edge entering DONE so it is fresh while frame_valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
        end else if (last_capture) begin
            frame_q <= frame_d;
        end
    end

    assign sel         = sel_q;
    assign frame       = frame_q;
    assign frame_valid = (state_q == ST_DONE);
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (DWELL=4 and DWELL=1) each scanning
// a behavioural 4:1 mux, checked cycle by cycle against a timing/packing model.
module tb_mux_scan_sequencer;

    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic       start_v [2];
    logic       auto_v  [2];
    logic [1:0] dat     [2][4];

    logic [1:0] sel0, sel1;
    logic [7:0] frame0, frame1;
    logic       valid0, valid1, busy0, busy1;
    wire  [1:0] y0 = dat[0][sel0];
    wire  [1:0] y1 = dat[1][sel1];

    int errors = 0;
    int checks = 0;

    logic [7:0] frame_m  [2];
    logic [1:0] sel_hold [2];
    logic [1:0] hist [1024][4];

    always #5 clk = ~clk;

    mux_scan_sequencer #(.DWELL(4), .CW(CW)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .auto(auto_v[0]), .y_in(y0),
        .sel(sel0), .frame(frame0), .frame_valid(valid0), .busy(busy0)
    );

    mux_scan_sequencer #(.DWELL(1), .CW(CW)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .auto(auto_v[1]), .y_in(y1),
        .sel(sel1), .frame(frame1), .frame_valid(valid1), .busy(busy1)
    );

    function automatic int dw(input int u);
        return (u == 0) ? 4 : 1;
    endfunction

    function automatic logic [1:0] get_sel(input int u);
        return (u == 0) ? sel0 : sel1;
    endfunction

    function automatic logic [7:0] get_frame(input int u);
        return (u == 0) ? frame0 : frame1;
    endfunction

    function automatic logic get_valid(input int u);
        return (u == 0) ? valid0 : valid1;
    endfunction

    function automatic logic get_busy(input int u);
        return (u == 0) ? busy0 : busy1;
    endfunction

    // Start is high in cycle t=0; scans of period P then follow, then 4 idle cycles.
    // Random start pulses are sprayed while busy and must be ignored.
    task automatic run_scan(input int u, input int nscans, input bit rnd, input bit new_d0);
        int D = dw(u);
        int P = 4 * (D + 1) + 1;
        int T = 1 + nscans * P + 4;
        for (int t = 0; t < T; t++) begin
            int s;
            int ph;
            logic [1:0] e_sel;
            logic       e_busy;
            logic       e_valid;
            @(posedge clk);
            #1;
            if (t == 0)
                start_v[u] = 1'b1;
            else if (t <= nscans * P)
                start_v[u] = ($urandom % 3 == 0);
            else
                start_v[u] = 1'b0;
            if (t >= 1 && t <= nscans * P && (t % P) == 0)
                auto_v[u] = (t < nscans * P);
            else
                auto_v[u] = 1'($urandom % 2);
            if (rnd) begin
                for (int c = 0; c < 4; c++) dat[u][c] = 2'($urandom % 4);
            end else if (new_d0 && t == P + 1) begin
                dat[u][0] = 2'd3;
            end
            for (int c = 0; c < 4; c++) hist[t][c] = dat[u][c];

            @(negedge clk);
            if (t == 0) begin
                e_busy = 1'b0; e_valid = 1'b0; e_sel = sel_hold[u];
            end else if (t <= nscans * P) begin
                s  = (t - 1) / P;
                ph = (t - 1) % P;
                e_busy  = 1'b1;
                e_valid = (ph == P - 1);
                e_sel   = e_valid ? 2'd3 : 2'(ph / (D + 1));
                if (e_valid) begin
                    for (int c = 0; c < 4; c++)
                        frame_m[u][c*2 +: 2] = hist[1 + s*P + c*(D+1) + D][c];
                    $display("scan dwell=%0d t=%0d frame=%h expect=%h", D, t, get_frame(u), frame_m[u]);
                end
            end else begin
                e_busy = 1'b0; e_valid = 1'b0; e_sel = 2'd3;
            end
            checks++;
            if (get_sel(u) !== e_sel) begin
                errors++;
                $display("FAIL sel dwell=%0d t=%0d got=%0d exp=%0d", D, t, get_sel(u), e_sel);
            end
            checks++;
            if (get_busy(u) !== e_busy) begin
                errors++;
                $display("FAIL busy dwell=%0d t=%0d got=%b exp=%b", D, t, get_busy(u), e_busy);
            end
            checks++;
            if (get_valid(u) !== e_valid) begin
                errors++;
                $display("FAIL frame_valid dwell=%0d t=%0d got=%b exp=%b", D, t, get_valid(u), e_valid);
            end
            checks++;
            if (get_frame(u) !== frame_m[u]) begin
                errors++;
                $display("FAIL frame dwell=%0d t=%0d got=%h exp=%h", D, t, get_frame(u), frame_m[u]);
            end
        end
        if (nscans > 0) sel_hold[u] = 2'd3;
    endtask

    task automatic check_all_reset(input string tag);
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (get_sel(u) !== 2'd0 || get_frame(u) !== 8'h00 ||
                get_valid(u) !== 1'b0 || get_busy(u) !== 1'b0) begin
                errors++;
                $display("FAIL %s u=%0d got sel=%0d frame=%h valid=%b busy=%b exp all zero",
                         tag, u, get_sel(u), get_frame(u), get_valid(u), get_busy(u));
            end
        end
        frame_m[0] = '0; frame_m[1] = '0;
        sel_hold[0] = '0; sel_hold[1] = '0;
    endtask

    task automatic test_reset();
        #12;
        rst_n = 1'b0;
        #1;
        check_all_reset("reset_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic set_fixed(input int u);
        dat[u][0] = 2'd0; dat[u][1] = 2'd2; dat[u][2] = 2'd1; dat[u][3] = 2'd3;
    endtask

    task automatic test_single_scan();
        set_fixed(0);
        run_scan(0, 1, 1'b0, 1'b0);
        checks++;
        if (frame0 !== 8'hD8) begin
            errors++;
            $display("FAIL single_scan_frame got=%h exp=d8", frame0);
        end
    endtask

    task automatic test_auto();
        set_fixed(0);
        run_scan(0, 2, 1'b0, 1'b1);
        checks++;
        if (frame0 !== 8'hDB) begin
            errors++;
            $display("FAIL auto_second_frame got=%h exp=db", frame0);
        end
    endtask

    task automatic test_back_to_back_random();
        run_scan(0, 3, 1'b1, 1'b0);
        run_scan(0, 1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_scan();
        for (int t = 0; t <= 12; t++) begin
            @(posedge clk);
            #1;
            start_v[0] = (t == 0);
            auto_v[0]  = 1'b0;
            for (int c = 0; c < 4; c++) dat[0][c] = 2'($urandom % 4);
        end
        #3;
        checks++;
        if (sel0 !== 2'd2 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL mid_scan_position got sel=%0d busy=%b exp sel=2 busy=1", sel0, busy0);
        end
        rst_n = 1'b0;
        #1;
        check_all_reset("reset_mid_scan");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset mid-scan released");
        run_scan(0, 1, 1'b1, 1'b0);
    endtask

    task automatic test_dwell1();
        set_fixed(1);
        run_scan(1, 1, 1'b0, 1'b0);
        checks++;
        if (frame1 !== 8'hD8) begin
            errors++;
            $display("FAIL dwell1_frame got=%h exp=d8", frame1);
        end
        run_scan(1, 2, 1'b1, 1'b0);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            start_v[u] = 1'b0;
            auto_v[u]  = 1'b0;
            for (int c = 0; c < 4; c++) dat[u][c] = 2'd0;
            frame_m[u]  = '0;
            sel_hold[u] = '0;
        end
        test_reset();
        test_single_scan();
        test_auto();
        test_back_to_back_random();
        test_reset_mid_scan();
        test_dwell1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
